// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nibble_serial_pkg;

  // Sequencer states: waiting for a request, adding nibbles, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NIBBLES_DEF = 4;

  // Nibble index width; never narrower than one bit so NIBBLES=1 still has a counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NIBBLES_DEF);

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Host-side bundle for the nibble-serial adder: request, operands, status, result.
// Latency: n/a (wiring only); optional sub input exists when NIBBLE_SERIAL_SUB_EN is defined.
// Backpressure: none; start is simply ignored by the slave while busy.
interface nibble_serial_add_ctrl_if
  import nibble_serial_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
);
  logic                   start;
  logic                   cin;
  logic [4*NIBBLES-1:0]   x;
  logic [4*NIBBLES-1:0]   y;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic                   sub;
`endif
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   s;
  logic                   cout;

  modport master (
    output start, cin, x, y,
`ifdef NIBBLE_SERIAL_SUB_EN
    output sub,
`endif
    input  busy, done, s, cout
  );

  modport slave (
    input  start, cin, x, y,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  sub,
`endif
    output busy, done, s, cout
  );

endinterface

// File: rtl/adder4.sv
// Combinational 4-bit ripple-carry slice built from four full-adder cells.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module adder4 (
  input  logic       cin,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add (or subtract with NIBBLE_SERIAL_SUB_EN) done one nibble per clock through one adder4.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+NIBBLES.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
module nibble_serial_add_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_width(NIBBLES);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    s_q, s_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;

  logic [IW+1:0]   bit_base;
  logic [3:0]      nib_x, nib_y, nib_s;
  logic            nib_c;
  logic            last_nib;

  // Select the current operand nibbles by shifting so the index never needs a wide part-select.
  assign bit_base = {idx_q, 2'b00};
  assign nib_x    = 4'(x_q >> bit_base);
  assign nib_y    = 4'(y_q >> bit_base);
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  adder4 u_adder4 (
    .cin  (carry_q),
    .x    (nib_x),
    .y    (nib_y),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bus.start) begin
          x_d     = bus.x;
`ifdef NIBBLE_SERIAL_SUB_EN
          // Subtract as x + ~y + 1; the final carry then reads as "no borrow".
          y_d     = bus.sub ? ~bus.y : bus.y;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          y_d     = bus.y;
          carry_d = bus.cin;
`endif
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = (s_q & ~(W'(4'hF) << bit_base)) | (W'(nib_s) << bit_base);
        carry_d = nib_c;
        idx_d   = idx_q + IW'(1);
        if (last_nib) begin
          cout_d  = nib_c;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All sequencer state and outputs, cleared asynchronously so an in-flight op is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule
